wb_stage: RTL and testbench

- Writeback stage of the 5-stage pipeline: the MEM/WB pipeline register plus load-data extraction and the writeback select mux.
- Captures MEM-stage results on each clock edge.
- Drives the register file's write port (write enable, write address, write data) combinationally from the registered state.
- Has stall and flush controls from the hazard unit.

---
 rtl/wb_stage.sv | 158 +++++++++++++++
 tb/tb_wb_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage (MEM/WB register, load extraction, WD select).
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter output.
// Revision 1.0 - initial release.
`default_nettype none

module wb_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          mem_valid,
  input  logic          mem_RFWr,
  input  logic [RW-1:0] mem_rd,
  input  logic [1:0]    mem_WDSel,
  input  logic [2:0]    mem_DMType,
  input  logic [DW-1:0] mem_alu_out,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] mem_pc,
  output logic          RFWr,
  output logic [RW-1:0] A3,
  output logic [DW-1:0] WD,
  output logic          wb_valid,
  output logic [DW-1:0] wb_pc
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]   instret
`endif
);

  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LHU = 3'b010;
  localparam logic [2:0] DM_LB  = 3'b011;
  localparam logic [2:0] DM_LBU = 3'b100;

  localparam logic [1:0] WD_LOAD = 2'b01;
  localparam logic [1:0] WD_PC4  = 2'b10;

  logic          valid_q,   valid_d;
  logic          rfwr_q,    rfwr_d;
  logic [RW-1:0] rd_q,      rd_d;
  logic [1:0]    wdsel_q,   wdsel_d;
  logic [2:0]    dmtype_q,  dmtype_d;
  logic [DW-1:0] alu_out_q, alu_out_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic [DW-1:0] pc_q,      pc_d;

  // Flush beats stall; both only matter when reset is released.
  always_comb begin
    valid_d   = valid_q;
    rfwr_d    = rfwr_q;
    rd_d      = rd_q;
    wdsel_d   = wdsel_q;
    dmtype_d  = dmtype_q;
    alu_out_d = alu_out_q;
    rdata_d   = rdata_q;
    pc_d      = pc_q;
    if (flush_i) begin
      valid_d   = 1'b0;
      rfwr_d    = 1'b0;
      rd_d      = '0;
      wdsel_d   = '0;
      dmtype_d  = '0;
      alu_out_d = '0;
      rdata_d   = '0;
      pc_d      = '0;
    end else if (!stall_i) begin
      valid_d   = mem_valid;
      rfwr_d    = mem_RFWr;
      rd_d      = mem_rd;
      wdsel_d   = mem_WDSel;
      dmtype_d  = mem_DMType;
      alu_out_d = mem_alu_out;
      rdata_d   = mem_rdata;
      pc_d      = mem_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      rfwr_q    <= 1'b0;
      rd_q      <= '0;
      wdsel_q   <= '0;
      dmtype_q  <= '0;
      alu_out_q <= '0;
      rdata_q   <= '0;
      pc_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      rfwr_q    <= rfwr_d;
      rd_q      <= rd_d;
      wdsel_q   <= wdsel_d;
      dmtype_q  <= dmtype_d;
      alu_out_q <= alu_out_d;
      rdata_q   <= rdata_d;
      pc_q      <= pc_d;
    end
  end

  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_val;

  always_comb begin
    ld_byte = 8'h00;
    case (alu_out_q[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    // Half-word alignment is guaranteed upstream, so only bit 1 selects.
    ld_half = alu_out_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (dmtype_q)
      DM_LH:   ld_val = {{(DW-16){ld_half[15]}}, ld_half};
      DM_LHU:  ld_val = {{(DW-16){1'b0}}, ld_half};
      DM_LB:   ld_val = {{(DW-8){ld_byte[7]}}, ld_byte};
      DM_LBU:  ld_val = {{(DW-8){1'b0}}, ld_byte};
      default: ld_val = rdata_q;
    endcase
  end

  always_comb begin
    case (wdsel_q)
      WD_LOAD: WD = ld_val;
      WD_PC4:  WD = pc_q + DW'(4);
      default: WD = alu_out_q;
    endcase
  end

  assign RFWr     = valid_q & rfwr_q & (rd_q != '0);
  assign A3       = rd_q;
  assign wb_valid = valid_q;
  assign wb_pc    = pc_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (!flush_i && !stall_i && mem_valid)
      instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) instret_q <= '0;
    else      instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed plan cases plus randomized traffic.
`default_nettype none

module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, mem_valid, mem_RFWr;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_WDSel;
  logic [2:0]  mem_DMType;
  logic [31:0] mem_alu_out, mem_rdata, mem_pc;
  logic        RFWr, wb_valid;
  logic [4:0]  A3;
  logic [31:0] WD, wb_pc;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  wb_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .mem_valid(mem_valid), .mem_RFWr(mem_RFWr), .mem_rd(mem_rd),
    .mem_WDSel(mem_WDSel), .mem_DMType(mem_DMType),
    .mem_alu_out(mem_alu_out), .mem_rdata(mem_rdata), .mem_pc(mem_pc),
    .RFWr(RFWr), .A3(A3), .WD(WD), .wb_valid(wb_valid), .wb_pc(wb_pc)
`ifdef WB_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, stall, flush, valid, rfwr;
    bit [4:0] rd; bit [1:0] wdsel; bit [2:0] dmt;
    bit [31:0] alu, rdata, pc;
  } stim_t;

  typedef struct {
    bit rfwr; bit [4:0] a3; bit [31:0] wd; bit valid; bit [31:0] pc; bit [63:0] instret;
  } exp_t;

  exp_t  sb[$];
  stim_t m;            // model of the instruction currently sitting in WB
  bit [63:0] m_instret = 0;
  int tests = 0;
  int fails = 0;

  function automatic bit [31:0] load_value(bit [2:0] dmt, bit [31:0] addr, bit [31:0] word);
    bit [31:0] b, h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = ((addr / 2) % 2 == 1) ? (word >> 16) : (word & 32'hFFFF);
    case (dmt)
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      default: return word;
    endcase
  endfunction

  // Apply one cycle of stimulus; the model predicts what WB shows after the edge.
  task automatic step(input stim_t s);
    exp_t e;
    rst = s.rst; stall_i = s.stall; flush_i = s.flush; mem_valid = s.valid;
    mem_RFWr = s.rfwr; mem_rd = s.rd; mem_WDSel = s.wdsel; mem_DMType = s.dmt;
    mem_alu_out = s.alu; mem_rdata = s.rdata; mem_pc = s.pc;
    if (!s.rst) begin
      m = '{default: 0};
      m_instret = 0;
    end else if (s.flush) begin
      m = '{default: 0};
    end else if (!s.stall) begin
      m = s;
      if (s.valid) m_instret = m_instret + 1;
    end
    e.rfwr    = m.valid && m.rfwr && (m.rd != 0);
    e.a3      = m.rd;
    e.valid   = m.valid;
    e.pc      = m.pc;
    e.instret = m_instret;
    if (m.wdsel == 2'd1)      e.wd = load_value(m.dmt, m.alu, m.rdata);
    else if (m.wdsel == 2'd2) e.wd = m.pc + 32'd4;
    else                      e.wd = m.alu;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("RFWr", 64'(RFWr), 64'(e.rfwr));
        chk("A3", 64'(A3), 64'(e.a3));
        chk("WD", 64'(WD), 64'(e.wd));
        chk("wb_valid", 64'(wb_valid), 64'(e.valid));
        chk("wb_pc", 64'(wb_pc), 64'(e.pc));
`ifdef WB_INSTRET_EN
        chk("instret", instret, e.instret);
`endif
      end
    end
  end

  function automatic stim_t mk(bit [4:0] rd, bit [1:0] wdsel, bit [2:0] dmt,
                               bit [31:0] alu, bit [31:0] rdata, bit [31:0] pc);
    stim_t s;
    s.rst = 1; s.stall = 0; s.flush = 0; s.valid = 1; s.rfwr = 1;
    s.rd = rd; s.wdsel = wdsel; s.dmt = dmt; s.alu = alu; s.rdata = rdata; s.pc = pc;
    return s;
  endfunction

  initial begin : driver
    stim_t s;
    // Reset with arbitrary inputs
    s = mk(5'd9, 2'd1, 3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1000);
    s.rst = 0;
    step(s); step(s);
    // ALU writeback, then rd==0
    step(mk(5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h100));
    step(mk(5'd0, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h104));
    // Loads from 0x80FF7F01
    step(mk(5'd1, 2'd1, 3'd3, 32'h2003, 32'h80FF_7F01, 32'h108));
    step(mk(5'd2, 2'd1, 3'd4, 32'h2001, 32'h80FF_7F01, 32'h10C));
    step(mk(5'd3, 2'd1, 3'd1, 32'h2002, 32'h80FF_7F01, 32'h110));
    step(mk(5'd4, 2'd1, 3'd2, 32'h2000, 32'h80FF_7F01, 32'h114));
    step(mk(5'd6, 2'd1, 3'd0, 32'h2000, 32'h80FF_7F01, 32'h118));
    step(mk(5'd7, 2'd1, 3'd6, 32'h2003, 32'h80FF_7F01, 32'h11C));
    // PC+4 including wrap
    step(mk(5'd8, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_0FFC));
    step(mk(5'd8, 2'd2, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC));
    step(mk(5'd9, 2'd3, 3'd0, 32'hA5A5_0003, 32'h0, 32'h200));
    // Stall three cycles with new inputs present
    step(mk(5'd10, 2'd0, 3'd0, 32'h0000_00AA, 32'h0, 32'h300));
    for (int i = 0; i < 3; i++) begin
      s = mk(5'(11 + i), 2'd0, 3'd0, 32'h1111_0000 + i, 32'h0, 32'h400 + 4 * i);
      s.stall = 1;
      step(s);
    end
    // Flush together with stall
    s.flush = 1;
    step(s);
    // Reset while a valid instruction is held by stall, then resume
    step(mk(5'd12, 2'd0, 3'd0, 32'h0000_0BBB, 32'h0, 32'h500));
    s = mk(5'd13, 2'd0, 3'd0, 32'h0000_0CCC, 32'h0, 32'h504);
    s.stall = 1;
    step(s);
    s.rst = 0;
    step(s);
    step(mk(5'd14, 2'd1, 3'd3, 32'h3001, 32'h0000_8000, 32'h508));
    step(mk(5'd15, 2'd0, 3'd0, 32'h0000_0DDD, 32'h0, 32'h50C));
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s.rst   = ($urandom_range(0, 99) >= 3);
      s.stall = ($urandom_range(0, 99) < 20);
      s.flush = ($urandom_range(0, 99) < 8);
      s.valid = ($urandom_range(0, 99) < 80);
      s.rfwr  = ($urandom_range(0, 99) < 75);
      s.rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      s.wdsel = 2'($urandom);
      s.dmt   = 3'($urandom);
      s.alu   = $urandom;
      s.rdata = $urandom;
      s.pc    = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step(s);
    end
    @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
